brush_draw_engine: RTL and testbench
====================================

BRUSH_DRAW_ENGINE -- requirements
Module: brush_draw_engine

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 320: drawable width in pixels.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 240: drawable height in pixels.
REQ-003 SHALL have parameter COLOUR_BITS, default 3: pixel colour width.
REQ-004 SHALL have parameter MAX_BRUSH, default 8: largest brush edge in pixels, a power of two, at least 2.
REQ-005 SHALL have parameter BG_COLOUR, default 0: erase and clear colour.
REQ-006 SHALL define XW = $clog2(SCREEN_WIDTH), YW = $clog2(SCREEN_HEIGHT) and BW = $clog2(MAX_BRUSH).
REQ-007 SHALL have port iClk, input, 1: the single clock; all logic runs on its rising edge.
REQ-008 SHALL have port iResetn, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port iClear, input, 1: level-sensitive request to clear the screen.
REQ-010 SHALL have port iColour, input, COLOUR_BITS: paint colour.
REQ-011 SHALL have port iX_cell, input, XW: cursor x.
REQ-012 SHALL have port iY_cell, input, YW: cursor y.
REQ-013 SHALL have port iLeftbtn, input, 1: paint request.
REQ-014 SHALL have port iRightbtn, input, 1: erase request.
REQ-015 SHALL have port iBrushSize, input, BW: brush edge minus 1, giving an edge of iBrushSize+1.
REQ-016 SHALL have port oX_pixel, output, XW: plot x.
REQ-017 SHALL have port oY_pixel, output, YW: plot y.
REQ-018 SHALL have port oColour, output, COLOUR_BITS: plot colour.
REQ-019 SHALL have port oPlot, output, 1: write strobe qualifying oX_pixel, oY_pixel and oColour in the same cycle.
REQ-020 SHALL have port oBusy, output, 1: high in PAINT or CLEAR.
REQ-021 SHALL have port oClearDone, output, 1: one-cycle pulse after the last clear pixel.

Function
REQ-022 SHALL implement three states, IDLE, PAINT and CLEAR, with all outputs registered.
REQ-023 In IDLE, iClear high SHALL enter CLEAR on the next edge, taking priority over both buttons.
REQ-024 In IDLE with iClear low, iLeftbtn or iRightbtn high SHALL latch the origin (iX_cell, iY_cell), the edge E = iBrushSize+1 and the colour, then enter PAINT.
REQ-025 The latched colour SHALL be iColour when iLeftbtn is high, and BG_COLOUR when only iRightbtn is high; left wins when both buttons are high.
REQ-026 PAINT SHALL emit one pixel per cycle in raster order, dx fastest, with dx and dy each running 0..E-1, so a stroke lasts E*E cycles.
REQ-027 The first pixel SHALL appear with oPlot high in the cycle after the button is sampled.
REQ-028 After the last pixel, PAINT SHALL return to IDLE with oPlot low for at least one cycle.
REQ-029 Dedup: a request whose origin, E and colour all equal the last completed stroke SHALL NOT start PAINT and SHALL stay in IDLE.
REQ-030 iClear high during PAINT SHALL abort the stroke at the next edge and enter CLEAR.
REQ-031 An aborted stroke SHALL NOT update the last-stroke record.
REQ-032 CLEAR SHALL sweep x = 0..SCREEN_WIDTH-1 (fastest) and y = 0..SCREEN_HEIGHT-1, one pixel per cycle with colour BG_COLOUR and oPlot high, lasting SCREEN_WIDTH*SCREEN_HEIGHT cycles.
REQ-033 CLEAR SHALL NOT be interruptible by buttons or by iClear.
REQ-034 CLEAR SHALL pulse oClearDone in the cycle after its last pixel, invalidate the last-stroke record and return to IDLE.
REQ-035 iClear still high on returning to IDLE SHALL start a new clear.
REQ-036 Pixel coordinates SHALL be computed at XW+1 and YW+1 bits; the edge handling then follows Configuration.
REQ-037 oX_pixel, oY_pixel and oColour SHALL hold their last values while oPlot is low.

Reset
REQ-038 While iResetn is low, state SHALL be IDLE and every output 0.
REQ-039 While iResetn is low, the latched origin, edge and colour and the counters SHALL be 0, and the last-stroke record invalid.
REQ-040 Reset asserted mid-PAINT or mid-CLEAR SHALL drop oPlot immediately (asynchronously), with no further pixels emitted.
REQ-041 After reset release, the first edge SHALL evaluate IDLE rules.

Configuration
REQ-042 With BRUSH_CLIP_EN defined, brush pixels with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT SHALL consume their cycle with oPlot low.
REQ-043 Without BRUSH_CLIP_EN, the latched origin SHALL be clamped to min(x, SCREEN_WIDTH-E) and min(y, SCREEN_HEIGHT-E), so every stroke pixel is on screen with oPlot high.

Verification
REQ-044 Reset, then iLeftbtn=1, iColour=5, cursor (10,20), iBrushSize=1 -> 4 plots (10,20), (11,20), (10,21), (11,21) of colour 5 in consecutive cycles starting 1 cycle after sampling; oBusy high for 4 cycles.
REQ-045 Hold iLeftbtn with cursor, colour and size unchanged after REQ-044 -> no further oPlot.
REQ-046 Move the cursor to (11,20) -> new 4-pixel stroke; iRightbtn alone at (11,20) -> 4 plots of colour 0.
REQ-047 Pulse iClear on the 2nd pixel of a size-4 stroke -> stroke aborts; 76800 plots of colour 0 from (0,0) to (319,239); oClearDone one cycle after (319,239).
REQ-048 iBrushSize=7 at (318,238) -> with BRUSH_CLIP_EN, 4 plots high out of 64 cycles; without it, 64 plots with the origin clamped to (312,232).
REQ-049 Assert iResetn low mid-CLEAR -> oPlot=0, oBusy=0 immediately; after release, idle until a new request.

Source files
------------

// File: rtl/brush_draw_engine.sv
// Square-brush pixel plotter with a full-screen clear sweep; one pixel per clock, all outputs registered.
// Define BRUSH_CLIP_EN to suppress off-screen brush pixels instead of clamping the stroke origin.
module brush_draw_engine #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240,
    parameter int COLOUR_BITS   = 3,
    parameter int MAX_BRUSH     = 8,
    parameter int BG_COLOUR     = 0
) (
    input  logic                     iClk,
    input  logic                     iResetn,
    input  logic                     iClear,
    input  logic [COLOUR_BITS-1:0]   iColour,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]  iX_cell,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0] iY_cell,
    input  logic                     iLeftbtn,
    input  logic                     iRightbtn,
    input  logic [$clog2(MAX_BRUSH)-1:0]     iBrushSize,
    output logic [$clog2(SCREEN_WIDTH)-1:0]  oX_pixel,
    output logic [$clog2(SCREEN_HEIGHT)-1:0] oY_pixel,
    output logic [COLOUR_BITS-1:0]   oColour,
    output logic                     oPlot,
    output logic                     oBusy,
    output logic                     oClearDone
);
    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);
    localparam int BW = $clog2(MAX_BRUSH);
    localparam logic [COLOUR_BITS-1:0] BG = COLOUR_BITS'(BG_COLOUR);

    typedef enum logic [1:0] {S_IDLE, S_PAINT, S_CLEAR} state_t;
    state_t r_state, w_state_nxt;

    logic [XW-1:0]          r_ox, r_cx, r_last_x, r_xp;
    logic [YW-1:0]          r_oy, r_cy, r_last_y, r_yp;
    logic [BW:0]            r_edge, r_last_e;
    logic [BW-1:0]          r_dx, r_dy;
    logic [COLOUR_BITS-1:0] r_col, r_last_col, r_col_o;
    logic                   r_last_vld, r_plot, r_busy, r_done;

    logic [BW:0]            w_req_e;
    logic [XW-1:0]          w_req_x, w_cx_nxt, w_xp_nxt;
    logic [YW-1:0]          w_req_y, w_cy_nxt, w_yp_nxt;
    logic [COLOUR_BITS-1:0] w_req_col, w_col_nxt;
    logic [BW-1:0]          w_dx_nxt, w_dy_nxt;
    logic [XW:0]            w_pix_x;
    logic [YW:0]            w_pix_y;
    logic w_dup, w_start, w_dx_end, w_dy_end, w_last_px, w_cx_end, w_last_clr, w_in_range;
    logic w_plot_nxt, w_done_nxt;

    assign w_req_e   = {1'b0, iBrushSize} + (BW+1)'(1);
    assign w_req_col = iLeftbtn ? iColour : BG;

`ifdef BRUSH_CLIP_EN
    assign w_req_x = iX_cell;
    assign w_req_y = iY_cell;
`else
    // Pull the origin in so the whole E x E square lands on screen.
    logic [XW:0] w_lim_x;
    logic [YW:0] w_lim_y;
    assign w_lim_x = (XW+1)'(SCREEN_WIDTH)  - (XW+1)'(w_req_e);
    assign w_lim_y = (YW+1)'(SCREEN_HEIGHT) - (YW+1)'(w_req_e);
    assign w_req_x = ({1'b0, iX_cell} > w_lim_x) ? w_lim_x[XW-1:0] : iX_cell;
    assign w_req_y = ({1'b0, iY_cell} > w_lim_y) ? w_lim_y[YW-1:0] : iY_cell;
`endif

    assign w_dup   = r_last_vld && (w_req_x == r_last_x) && (w_req_y == r_last_y) &&
                     (w_req_e == r_last_e) && (w_req_col == r_last_col);
    assign w_start = (iLeftbtn || iRightbtn) && !w_dup;

    assign w_dx_end  = ({1'b0, r_dx} == r_edge - (BW+1)'(1));
    assign w_dy_end  = ({1'b0, r_dy} == r_edge - (BW+1)'(1));
    assign w_last_px = w_dx_end && w_dy_end;
    assign w_dx_nxt  = w_dx_end ? '0 : r_dx + BW'(1);
    assign w_dy_nxt  = w_dx_end ? r_dy + BW'(1) : r_dy;

    assign w_cx_end   = (r_cx == XW'(SCREEN_WIDTH - 1));
    assign w_last_clr = w_cx_end && (r_cy == YW'(SCREEN_HEIGHT - 1));
    assign w_cx_nxt   = w_cx_end ? '0 : r_cx + XW'(1);
    assign w_cy_nxt   = w_cx_end ? r_cy + YW'(1) : r_cy;

    // Coordinate of the pixel to be shown next cycle, one bit wider to catch overflow.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_pix_x = {1'b0, w_req_x};
            w_pix_y = {1'b0, w_req_y};
        end else begin
            w_pix_x = {1'b0, r_ox} + (XW+1)'(w_dx_nxt);
            w_pix_y = {1'b0, r_oy} + (YW+1)'(w_dy_nxt);
        end
    end
    assign w_in_range = (w_pix_x < (XW+1)'(SCREEN_WIDTH)) && (w_pix_y < (YW+1)'(SCREEN_HEIGHT));

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (iClear) w_state_nxt = S_CLEAR;
                     else if (w_start) w_state_nxt = S_PAINT;
            S_PAINT: if (iClear) w_state_nxt = S_CLEAR;
                     else if (w_last_px) w_state_nxt = S_IDLE;
            S_CLEAR: if (w_last_clr) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_plot_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_xp_nxt   = r_xp;
        w_yp_nxt   = r_yp;
        w_col_nxt  = r_col_o;
        case (r_state)
            S_IDLE, S_PAINT: begin
                if (iClear) begin
                    w_plot_nxt = 1'b1;
                    w_xp_nxt   = '0;
                    w_yp_nxt   = '0;
                    w_col_nxt  = BG;
                end else if ((r_state == S_IDLE) ? w_start : !w_last_px) begin
                    w_plot_nxt = w_in_range;
                    if (w_in_range) begin
                        w_xp_nxt  = w_pix_x[XW-1:0];
                        w_yp_nxt  = w_pix_y[YW-1:0];
                        w_col_nxt = (r_state == S_IDLE) ? w_req_col : r_col;
                    end
                end
            end
            S_CLEAR: begin
                if (w_last_clr) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_plot_nxt = 1'b1;
                    w_xp_nxt   = w_cx_nxt;
                    w_yp_nxt   = w_cy_nxt;
                    w_col_nxt  = BG;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            r_ox <= '0; r_oy <= '0; r_edge <= '0; r_col <= '0;
            r_dx <= '0; r_dy <= '0; r_cx <= '0; r_cy <= '0;
            r_last_vld <= 1'b0; r_last_x <= '0; r_last_y <= '0;
            r_last_e <= '0; r_last_col <= '0;
            r_xp <= '0; r_yp <= '0; r_col_o <= '0;
            r_plot <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
        end else begin
            r_xp    <= w_xp_nxt;
            r_yp    <= w_yp_nxt;
            r_col_o <= w_col_nxt;
            r_plot  <= w_plot_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (iClear) begin
                        r_cx <= '0;
                        r_cy <= '0;
                    end else if (w_start) begin
                        r_ox   <= w_req_x;
                        r_oy   <= w_req_y;
                        r_edge <= w_req_e;
                        r_col  <= w_req_col;
                        r_dx   <= '0;
                        r_dy   <= '0;
                    end
                end
                S_PAINT: begin
                    if (iClear) begin
                        r_cx <= '0;
                        r_cy <= '0;
                    end else if (w_last_px) begin
                        r_last_vld <= 1'b1;
                        r_last_x   <= r_ox;
                        r_last_y   <= r_oy;
                        r_last_e   <= r_edge;
                        r_last_col <= r_col;
                    end else begin
                        r_dx <= w_dx_nxt;
                        r_dy <= w_dy_nxt;
                    end
                end
                S_CLEAR: begin
                    if (w_last_clr) begin
                        r_last_vld <= 1'b0;
                    end else begin
                        r_cx <= w_cx_nxt;
                        r_cy <= w_cy_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oX_pixel   = r_xp;
    assign oY_pixel   = r_yp;
    assign oColour    = r_col_o;
    assign oPlot      = r_plot;
    assign oBusy      = r_busy;
    assign oClearDone = r_done;
endmodule

// File: tb/tb_brush_draw_engine.sv
// Scoreboard bench for brush_draw_engine: stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_brush_draw_engine;
    logic       clk = 1'b0;
    logic       iResetn, iClear, iLeftbtn, iRightbtn;
    logic [2:0] iColour, iBrushSize;
    logic [8:0] iX_cell, oX_pixel;
    logic [7:0] iY_cell, oY_pixel;
    logic [2:0] oColour;
    logic       oPlot, oBusy, oClearDone;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } px_t;

    px_t q[$];
    int  n_chk = 0, n_fail = 0;
    int  plot_cnt = 0, busy_cnt = 0, done_cnt = 0;
    logic       prev_plot = 1'b0;
    logic [8:0] prev_x = '0;
    logic [7:0] prev_y = '0;

    brush_draw_engine dut (
        .iClk(clk), .iResetn(iResetn), .iClear(iClear), .iColour(iColour),
        .iX_cell(iX_cell), .iY_cell(iY_cell), .iLeftbtn(iLeftbtn), .iRightbtn(iRightbtn),
        .iBrushSize(iBrushSize), .oX_pixel(oX_pixel), .oY_pixel(oY_pixel), .oColour(oColour),
        .oPlot(oPlot), .oBusy(oBusy), .oClearDone(oClearDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_stroke(input int x0, input int y0, input int e, input int c);
        for (int dy = 0; dy < e; dy++)
            for (int dx = 0; dx < e; dx++)
                q.push_back('{x: 9'(x0 + dx), y: 8'(y0 + dy), c: 3'(c)});
    endtask

    task automatic push_clear();
        for (int y = 0; y < 240; y++)
            for (int x = 0; x < 320; x++)
                q.push_back('{x: 9'(x), y: 8'(y), c: 3'd0});
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((oBusy || q.size() != 0) && n < max);
        if (oBusy || q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL wait_idle_timeout: busy=%0d pending=%0d after %0d cycles", oBusy, q.size(), n);
        end
    endtask

    always @(negedge clk) begin
        if (iResetn) begin
            if (oPlot) begin
                plot_cnt++;
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_plot: got (%0d,%0d) c=%0d, expected no plot", oX_pixel, oY_pixel, oColour);
                end else begin
                    px_t e;
                    e = q.pop_front();
                    if (oX_pixel !== e.x || oY_pixel !== e.y || oColour !== e.c) begin
                        n_fail++;
                        $display("FAIL pixel: got (%0d,%0d) c=%0d, expected (%0d,%0d) c=%0d",
                                 oX_pixel, oY_pixel, oColour, e.x, e.y, e.c);
                    end
                end
            end
            if (oClearDone) begin
                done_cnt++;
                chk("done_after_last_pixel", {31'd0, prev_plot && prev_x == 9'd319 && prev_y == 8'd239 && !oPlot}, 32'd1);
            end
            if (oBusy) busy_cnt++;
            prev_plot = oPlot;
            prev_x    = oX_pixel;
            prev_y    = oY_pixel;
        end
    end

    initial begin
        int pc, n;
        iResetn = 1'b0; iClear = 1'b0; iLeftbtn = 1'b0; iRightbtn = 1'b0;
        iColour = '0; iBrushSize = '0; iX_cell = '0; iY_cell = '0;
        repeat (3) @(negedge clk);
        chk("rst_plot", oPlot, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oClearDone, 0);
        chk("rst_x", oX_pixel, 0);
        chk("rst_y", oY_pixel, 0);
        chk("rst_colour", oColour, 0);
        @(posedge clk); #1 iResetn = 1'b1;

        // 2x2 paint stroke
        @(posedge clk); #1;
        push_stroke(10, 20, 2, 5);
        busy_cnt = 0;
        iLeftbtn = 1'b1; iColour = 3'd5; iX_cell = 9'd10; iY_cell = 8'd20; iBrushSize = 3'd1;
        @(negedge clk);
        chk("pre_sample_no_plot", oPlot, 0);
        @(negedge clk);
        chk("first_pixel_latency", oPlot, 1);
        wait_idle(20);
        chk("stroke_busy_cycles", busy_cnt, 4);

        // held button, unchanged request
        pc = plot_cnt;
        repeat (10) @(negedge clk);
        #1;
        chk("dedup_no_plot", plot_cnt, pc);
        chk("hold_x", oX_pixel, 11);
        chk("hold_y", oY_pixel, 21);
        chk("hold_colour", oColour, 5);

        // moved cursor, then erase
        @(posedge clk); #1;
        push_stroke(11, 20, 2, 5);
        iX_cell = 9'd11;
        wait_idle(20);
        @(posedge clk); #1;
        push_stroke(11, 20, 2, 0);
        iLeftbtn = 1'b0; iRightbtn = 1'b1;
        wait_idle(20);
        repeat (4) @(posedge clk);
        #1 iRightbtn = 1'b0;

        // abort a 4x4 stroke on its second pixel with a clear
        push_stroke(50, 60, 1, 3);
        q.push_back('{x: 9'd51, y: 8'd60, c: 3'd3});
        push_clear();
        done_cnt = 0;
        iLeftbtn = 1'b1; iColour = 3'd3; iX_cell = 9'd50; iY_cell = 8'd60; iBrushSize = 3'd3;
        @(posedge clk); #1;
        @(posedge clk); #1 iClear = 1'b1; iLeftbtn = 1'b0;
        @(posedge clk); #1 iClear = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 80000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("clear_done_seen", done_cnt, 1);
        chk("clear_all_pixels", q.size(), 0);
        @(negedge clk); #1;
        chk("done_single_pulse", done_cnt, 1);
        chk("idle_after_clear", oBusy, 0);

        // record invalidated by clear: repeat of last completed stroke must draw
        @(posedge clk); #1;
        push_stroke(11, 20, 2, 0);
        iRightbtn = 1'b1; iX_cell = 9'd11; iY_cell = 8'd20; iBrushSize = 3'd1;
        wait_idle(20);
        #1 iRightbtn = 1'b0;

        // 8x8 brush at the bottom-right corner
        @(posedge clk); #1;
        busy_cnt = 0;
`ifdef BRUSH_CLIP_EN
        push_stroke(318, 238, 2, 6);
`else
        push_stroke(312, 232, 8, 6);
`endif
        iLeftbtn = 1'b1; iColour = 3'd6; iX_cell = 9'd318; iY_cell = 8'd238; iBrushSize = 3'd7;
        wait_idle(100);
        chk("corner_busy_cycles", busy_cnt, 64);
        #1 iLeftbtn = 1'b0;

        // reset in the middle of a clear
        @(posedge clk); #1;
        push_clear();
        iClear = 1'b1;
        @(posedge clk); #1 iClear = 1'b0;
        repeat (50) @(posedge clk);
        #3 iResetn = 1'b0;
        #1;
        chk("async_rst_plot", oPlot, 0);
        chk("async_rst_busy", oBusy, 0);
        q.delete();
        pc = plot_cnt;
        @(posedge clk); #1 iResetn = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("idle_after_reset_plots", plot_cnt, pc);
        chk("idle_after_reset_busy", oBusy, 0);

        // single-pixel brush after reset
        @(posedge clk); #1;
        push_stroke(0, 0, 1, 2);
        iLeftbtn = 1'b1; iColour = 3'd2; iX_cell = 9'd0; iY_cell = 8'd0; iBrushSize = 3'd0;
        wait_idle(20);
        #1 iLeftbtn = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
